// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO.
// Defaults match the legacy 8-bit x 16-entry buffer.
package fifo_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_AF_LEVEL = (1 << DEF_ADDR_W) - 2;
    localparam int DEF_AE_LEVEL = 2;

    // Read-mode encoding for the FWFT parameter
    localparam int MODE_FWFT = 1;
    localparam int MODE_REG  = 0;

    // Bits needed to hold values 0..n-1 (minimum 1)
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Deliberately unreset so it maps onto distributed RAM.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
)(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: wrap-bit pointers, occupancy/threshold flags,
// sticky overflow/underflow, synchronous flush and selectable FWFT/registered read.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = (1 << ADDR_W) - 2,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    parameter int FWFT     = MODE_FWFT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              Clr,
    input  logic              W_en,
    input  logic [DATA_W-1:0] W_data,
    input  logic              R_en,
    output logic [DATA_W-1:0] R_data,
    output logic              Empty,
    output logic              Full,
    output logic              Almost_empty,
    output logic              Almost_full,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow,
    output logic              Underflow
);

    localparam logic [ADDR_W:0] C_AF      = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] C_AE      = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] C_PTR_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic              r_ovf;
    logic              r_unf;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [ADDR_W:0]   w_count;
    logic [DATA_W-1:0] w_rdata;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]) &&
                     (r_wptr[ADDR_W] != r_rptr[ADDR_W]);
    assign w_count = r_wptr - r_rptr;

    // Flush wins over both requests, so the memory is not written under Clr
    assign w_wr_ok = W_en & ~w_full  & ~Clr;
    assign w_rd_ok = R_en & ~w_empty & ~Clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (Clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + C_PTR_ONE;
            if (w_rd_ok) r_rptr <= r_rptr + C_PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (Clr) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (W_en && w_full)  r_ovf <= 1'b1;
            if (R_en && w_empty) r_unf <= 1'b1;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wptr[ADDR_W-1:0]),
        .i_wdata (W_data),
        .i_raddr (r_rptr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            assign R_data = w_rdata;
        end else begin : g_reg
            logic [DATA_W-1:0] r_rdata;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_rdata <= '0;
                end else if (w_rd_ok) begin
                    r_rdata <= w_rdata;
                end
            end
            assign R_data = r_rdata;
        end
    endgenerate

    assign Empty        = w_empty;
    assign Full         = w_full;
    assign Count        = w_count;
    assign Almost_full  = (w_count >= C_AF);
    assign Almost_empty = (w_count <= C_AE);
    assign Overflow     = r_ovf;
    assign Underflow    = r_unf;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench: default FWFT 8x16 FIFO (u_a) and registered-read 32x8 FIFO (u_b).
module tb_fifo_param;

    logic clk;
    int   n_vec;
    int   n_err;

    logic        a_rst, a_clr, a_we, a_re;
    logic [7:0]  a_wd, a_rd;
    logic        a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
    logic [4:0]  a_cnt;

    logic        b_rst, b_clr, b_we, b_re;
    logic [31:0] b_wd, b_rd;
    logic        b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
    logic [3:0]  b_cnt;

    fifo_param u_a (
        .clk(clk), .rst(a_rst), .Clr(a_clr), .W_en(a_we), .W_data(a_wd),
        .R_en(a_re), .R_data(a_rd), .Empty(a_empty), .Full(a_full),
        .Almost_empty(a_ae), .Almost_full(a_af), .Count(a_cnt),
        .Overflow(a_ovf), .Underflow(a_unf)
    );

    fifo_param #(
        .DATA_W(32), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)
    ) u_b (
        .clk(clk), .rst(b_rst), .Clr(b_clr), .W_en(b_we), .W_data(b_wd),
        .R_en(b_re), .R_data(b_rd), .Empty(b_empty), .Full(b_full),
        .Almost_empty(b_ae), .Almost_full(b_af), .Count(b_cnt),
        .Overflow(b_ovf), .Underflow(b_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus on u_a; returns 1 time unit after the edge
    task automatic cyc_a(input logic we, input logic [7:0] wd, input logic re, input logic clr);
        a_we = we; a_wd = wd; a_re = re; a_clr = clr;
        @(posedge clk); #1;
        a_we = 1'b0; a_re = 1'b0; a_clr = 1'b0;
    endtask

    task automatic cyc_b(input logic we, input logic [31:0] wd, input logic re);
        b_we = we; b_wd = wd; b_re = re;
        @(posedge clk); #1;
        b_we = 1'b0; b_re = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b0; b_rst = 1'b0;
        a_clr = 0; a_we = 0; a_re = 0; a_wd = '0;
        b_clr = 0; b_we = 0; b_re = 0; b_wd = '0;
        #3;
        n_vec++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", a_empty); end
        n_vec++; if (a_full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", a_full); end
        n_vec++; if (a_cnt !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", a_cnt); end
        n_vec++; if (a_ae !== 1'b1 || a_af !== 1'b0) begin n_err++; $display("FAIL reset_almost got ae=%b af=%b want ae=1 af=0", a_ae, a_af); end
        n_vec++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin n_err++; $display("FAIL reset_sticky got ovf=%b unf=%b want 0 0", a_ovf, a_unf); end
        n_vec++; if (b_rd !== 32'h0) begin n_err++; $display("FAIL reset_rdata_reg got %h want 0", b_rd); end
        @(negedge clk);
        a_rst = 1'b1; b_rst = 1'b1;
        @(posedge clk); #1;
        $display("reset: released both instances");
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            cyc_a(1'b1, 8'(i), 1'b0, 1'b0);
            n_vec++; if (a_cnt !== 5'(i)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, a_cnt, i); end
            n_vec++; if (a_af !== (i >= 14)) begin n_err++; $display("FAIL fill_af[%0d] got %b want %b", i, a_af, (i >= 14)); end
            n_vec++; if (a_ae !== (i <= 2)) begin n_err++; $display("FAIL fill_ae[%0d] got %b want %b", i, a_ae, (i <= 2)); end
            n_vec++; if (a_full !== (i == 16)) begin n_err++; $display("FAIL fill_full[%0d] got %b want %b", i, a_full, (i == 16)); end
            $display("write %02h count=%0d", i[7:0], a_cnt);
        end
        cyc_a(1'b1, 8'hFF, 1'b0, 1'b0);
        n_vec++; if (a_cnt !== 5'd16 || a_full !== 1'b1) begin n_err++; $display("FAIL overflow_count got %0d full=%b want 16 full=1", a_cnt, a_full); end
        n_vec++; if (a_ovf !== 1'b1) begin n_err++; $display("FAIL overflow_flag got %b want 1", a_ovf); end
        n_vec++; if (a_rd !== 8'h01) begin n_err++; $display("FAIL overflow_head got %h want 01", a_rd); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            n_vec++; if (a_rd !== 8'(i)) begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, a_rd, 8'(i)); end
            cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
            n_vec++; if (a_cnt !== 5'(16 - i)) begin n_err++; $display("FAIL drain_count[%0d] got %0d want %0d", i, a_cnt, 16 - i); end
            $display("read  %02h count=%0d", i[7:0], a_cnt);
        end
        n_vec++; if (a_empty !== 1'b1 || a_unf !== 1'b0) begin n_err++; $display("FAIL drain_empty got empty=%b unf=%b want 1 0", a_empty, a_unf); end
        cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
        n_vec++; if (a_unf !== 1'b1 || a_cnt !== 5'd0) begin n_err++; $display("FAIL underflow got unf=%b count=%0d want 1 0", a_unf, a_cnt); end
        n_vec++; if (a_ovf !== 1'b1) begin n_err++; $display("FAIL overflow_sticky got %b want 1", a_ovf); end
        cyc_a(1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin n_err++; $display("FAIL clr_sticky got ovf=%b unf=%b want 0 0", a_ovf, a_unf); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) begin
            cyc_a(1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
            n_vec++; if (a_cnt !== 5'd1 || a_rd !== 8'(i + 8'h40)) begin n_err++; $display("FAIL wrap_write[%0d] got count=%0d data=%h want 1 %h", i, a_cnt, a_rd, 8'(i + 8'h40)); end
            cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
            n_vec++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL wrap_read[%0d] got empty=%b want 1", i, a_empty); end
        end
        $display("wrap: 40 write/read pairs done");
    endtask

    task automatic test_simul();
        for (int i = 0; i < 16; i++) cyc_a(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        n_vec++; if (a_full !== 1'b1) begin n_err++; $display("FAIL simul_prefill got full=%b want 1", a_full); end
        cyc_a(1'b1, 8'hAA, 1'b1, 1'b0);
        n_vec++; if (a_cnt !== 5'd15 || a_full !== 1'b0) begin n_err++; $display("FAIL simul_full_count got %0d full=%b want 15 0", a_cnt, a_full); end
        n_vec++; if (a_ovf !== 1'b1 || a_rd !== 8'h21) begin n_err++; $display("FAIL simul_full_ovf got ovf=%b head=%h want 1 21", a_ovf, a_rd); end
        for (int i = 1; i < 16; i++) begin
            n_vec++; if (a_rd !== 8'(8'h20 + i)) begin n_err++; $display("FAIL simul_drain[%0d] got %h want %h", i, a_rd, 8'(8'h20 + i)); end
            cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_vec++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL simul_drained got empty=%b want 1", a_empty); end
        cyc_a(1'b1, 8'h55, 1'b1, 1'b0);
        n_vec++; if (a_cnt !== 5'd1 || a_unf !== 1'b1 || a_rd !== 8'h55) begin n_err++; $display("FAIL simul_empty got count=%0d unf=%b data=%h want 1 1 55", a_cnt, a_unf, a_rd); end
        $display("simul: full and empty cases applied");
    endtask

    task automatic test_clr();
        cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc_a(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        n_vec++; if (a_cnt !== 5'd5 || a_unf !== 1'b1) begin n_err++; $display("FAIL clr_pre got count=%0d unf=%b want 5 1", a_cnt, a_unf); end
        cyc_a(1'b1, 8'h99, 1'b0, 1'b1);
        n_vec++; if (a_cnt !== 5'd0 || a_empty !== 1'b1) begin n_err++; $display("FAIL clr_count got count=%0d empty=%b want 0 1", a_cnt, a_empty); end
        n_vec++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin n_err++; $display("FAIL clr_flags got ovf=%b unf=%b want 0 0", a_ovf, a_unf); end
        cyc_a(1'b1, 8'h77, 1'b0, 1'b0);
        n_vec++; if (a_cnt !== 5'd1 || a_rd !== 8'h77) begin n_err++; $display("FAIL clr_after got count=%0d data=%h want 1 77", a_cnt, a_rd); end
        $display("clr: flush with concurrent write applied");
    endtask

    task automatic test_regmode();
        cyc_b(1'b1, 32'hDEADBEEF, 1'b0);
        n_vec++; if (b_empty !== 1'b0 || b_cnt !== 4'd1) begin n_err++; $display("FAIL reg_write got empty=%b count=%0d want 0 1", b_empty, b_cnt); end
        n_vec++; if (b_rd !== 32'h0) begin n_err++; $display("FAIL reg_hold got %h want 00000000", b_rd); end
        cyc_b(1'b0, 32'h0, 1'b1);
        n_vec++; if (b_rd !== 32'hDEADBEEF || b_empty !== 1'b1) begin n_err++; $display("FAIL reg_read got %h empty=%b want deadbeef 1", b_rd, b_empty); end
        for (int i = 0; i < 8; i++) cyc_b(1'b1, 32'h100 + i, 1'b0);
        n_vec++; if (b_full !== 1'b1 || b_cnt !== 4'd8 || b_af !== 1'b1) begin n_err++; $display("FAIL reg_full got full=%b count=%0d af=%b want 1 8 1", b_full, b_cnt, b_af); end
        // Reset lands between clock edges while a write is being presented
        b_we = 1'b1; b_wd = 32'hCAFE0000;
        #2 b_rst = 1'b0;
        #1;
        n_vec++; if (b_cnt !== 4'd0 || b_empty !== 1'b1 || b_full !== 1'b0) begin n_err++; $display("FAIL async_rst_ptr got count=%0d empty=%b full=%b want 0 1 0", b_cnt, b_empty, b_full); end
        n_vec++; if (b_rd !== 32'h0 || b_ae !== 1'b1 || b_af !== 1'b0) begin n_err++; $display("FAIL async_rst_out got data=%h ae=%b af=%b want 0 1 0", b_rd, b_ae, b_af); end
        n_vec++; if (b_ovf !== 1'b0 || b_unf !== 1'b0) begin n_err++; $display("FAIL async_rst_flags got ovf=%b unf=%b want 0 0", b_ovf, b_unf); end
        @(negedge clk);
        b_rst = 1'b1; b_we = 1'b0;
        @(posedge clk); #1;
        cyc_b(1'b1, 32'h12345678, 1'b0);
        cyc_b(1'b0, 32'h0, 1'b1);
        n_vec++; if (b_rd !== 32'h12345678 || b_empty !== 1'b1) begin n_err++; $display("FAIL post_rst_read got %h empty=%b want 12345678 1", b_rd, b_empty); end
        $display("regmode: registered read and async reset applied");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simul();
        test_clr();
        test_regmode();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO that replaces the fixed 8-bit × 16-entry buffer as the general-purpose single-clock queue between producer and consumer blocks. Adds configurable width and depth, overflow/underflow protection with sticky error flags, programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and a selectable read mode: first-word-fall-through or registered output.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries (ADDR_W ≥ 1)
- AF_LEVEL, DEPTH-2, Almost_full asserts when Count ≥ AF_LEVEL
- AE_LEVEL, 2, Almost_empty asserts when Count ≤ AE_LEVEL
- FWFT, 1, 1 = head word visible combinationally on R_data; 0 = R_data registered, valid one cycle after read
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-low
- Clr  in  1  synchronous flush: pointers to 0, sticky flags cleared
- W_en  in  1  write request
- W_data  in  DATA_W  write data
- R_en  in  1  read request
- R_data  out  DATA_W  read data
- Empty  out  1  Count == 0
- Full  out  1  Count == DEPTH
- Almost_empty  out  1  Count ≤ AE_LEVEL
- Almost_full  out  1  Count ≥ AF_LEVEL
- Count  out  ADDR_W+1  current occupancy, 0..DEPTH
- Overflow  out  1  sticky: write attempted while Full
- Underflow  out  1  sticky: read attempted while Empty

## Operation
- Pointers W_Ptr and R_Ptr are ADDR_W+1 bits wide. The low ADDR_W bits address memory; the MSB is the wrap bit.
- Empty = (W_Ptr == R_Ptr).
- Full = low bits equal and MSBs differ.
- Count = W_Ptr − R_Ptr, modulo 2**(ADDR_W+1).
- Write accepted: wr_ok = W_en & ~Full. On wr_ok, mem[W_Ptr low bits] ← W_data and W_Ptr increments.
- Read accepted: rd_ok = R_en & ~Empty. On rd_ok, R_Ptr increments.
- Rejected requests leave pointers and memory unchanged.
- Simultaneous W_en and R_en:
  - Neither Full nor Empty: both accepted, Count unchanged.
  - Full: read accepted, write rejected, Overflow set.
  - Empty: write accepted, read rejected, Underflow set.
- Overflow sets on W_en & Full. Underflow sets on R_en & Empty. Both hold until reset or Clr.
- Clr has priority over W_en and R_en in the same cycle:
  - Pointers go to 0 and sticky flags clear.
  - Memory contents are untouched.
  - The registered R_data keeps its value.
- FWFT=1: R_data = mem[R_Ptr low bits] combinationally. R_data is meaningful only while ~Empty.
- FWFT=0: an R_data register loads mem[R_Ptr low bits] on rd_ok and otherwise holds.
- Memory array is not reset.
- Pointers wrap naturally at 2**(ADDR_W+1); no special-case logic.

## Timing
- Reset (rst low, asynchronous):
  - W_Ptr and R_Ptr = 0, so Empty=1, Full=0, Count=0.
  - Almost_empty=1, Almost_full=0.
  - Overflow and Underflow = 0.
  - Registered R_data = 0.
- All status outputs are combinational from registered pointers. They reflect the state after the most recent edge, with no extra lag.
- Write-to-visible latency: a word written at edge N makes Empty deassert after edge N.
  - FWFT=1: the word is on R_data after edge N.
  - FWFT=0: R_en sampled at edge N+1 puts the word on R_data after edge N+1.
- Full/Empty at the sampling edge decide acceptance. A read at a full FIFO and a write at an empty FIFO each free or fill a slot that becomes usable only on the next cycle.
- An asynchronous reset in mid-transfer aborts it immediately. The next accepted write goes to address 0.

## Structure
- Shared package fifo_pkg holds:
  - clog2-style width helper
  - default DATA_W, ADDR_W, AF_LEVEL, AE_LEVEL constants
  - FWFT mode encoding (MODE_FWFT=1, MODE_REG=0)
- Sub-module fifo_mem: DEPTH × DATA_W array with one synchronous write port and one asynchronous read port. It has no reset.
- Top level holds pointers, flag logic, sticky flags and the optional R_data register, selected with a generate on FWFT.

## Test plan
- Reset, then write 0x01..0x10 (DEPTH=16) with no reads → Full=1, Count=16, Almost_full=1 from Count=14. Then 17th write of 0xFF → memory unchanged, Overflow=1, Count=16.
- Read 16 words (FWFT=1) → 0x01..0x10 in order, Empty=1 after the last read. Then R_en=1 once more → Underflow=1, R_Ptr unchanged.
- Wrap-around: 40 interleaved write/read pairs with data i → outputs equal inputs in order, Count stays ≤1, pointer MSB toggles.
- Simultaneous W_en=R_en=1:
  - At Full → one read, write rejected, Count 16→15, Overflow=1.
  - At Empty → write accepted, Count 0→1, Underflow=1.
- Clr while Count=5 with W_en=1 → Count=0, Empty=1, sticky flags 0, written word discarded.
- FWFT=0, DATA_W=32, ADDR_W=3: write 0xDEADBEEF, R_en → R_data=0xDEADBEEF one cycle after the read edge. Assert rst mid-burst → all outputs return to reset values asynchronously.
